fpu_req_driver: RTL
===================

Name: fpu_req_driver

Overview:
Initiator-side driver for the FPU operand/result handshake. It accepts operand triples and an opcode from a test sequencer or CPU-side requester, queues them, and issues them to an fpnew-style unit using the in_valid/in_ready and out_valid/out_ready handshakes. Each issued op carries a tag. Returned results are checked for in-order tags and buffered for the requester. A credit scheme bounds the number of ops in flight, and a flush drains the unit cleanly.

Parameters:
WIDTH, 32, operand/result width
OPW, 4, opcode width
TAGW, 3, tag width; tags wrap modulo 2**TAGW
DEPTH, 4, request queue entries (power of 2)
MAX_OUT, 4, max ops in flight plus buffered responses; must be <= 2**TAGW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  one-cycle pulse: drop queued requests, discard in-flight results
req_valid  in  1  request valid
req_ready  out  1  request queue not full
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_c  in  WIDTH  operand C
req_op  in  OPW  opcode
fpu_in_valid  out  1  issue valid to FPU
fpu_in_ready  in  1  FPU accepts operands
fpu_a  out  WIDTH  issued operand A
fpu_b  out  WIDTH  issued operand B
fpu_c  out  WIDTH  issued operand C
fpu_op  out  OPW  issued opcode
fpu_tag  out  TAGW  issued tag
fpu_out_valid  in  1  FPU result valid
fpu_out_ready  out  1  driver accepts result
fpu_result  in  WIDTH  FPU result
fpu_status  in  5  FPU exception flags
fpu_tag_o  in  TAGW  tag returned with result
rsp_valid  out  1  response valid
rsp_ready  in  1  requester accepts response
rsp_data  out  WIDTH  result
rsp_status  out  5  flags
rsp_tag  out  TAGW  tag of response
busy  out  1  state != IDLE
tag_err  out  1  sticky: returned tag != expected tag
state  out  2  IDLE=0, RUN=1, DRAIN=2

Behaviour:
- Reset values: all queues empty, credits=MAX_OUT, issue_tag=0, exp_tag=0, state=IDLE, tag_err=0. Outputs: fpu_in_valid=0, rsp_valid=0, busy=0, req_ready=1, fpu_out_ready=1. Reset mid-operation abandons all state immediately. FPU results arriving after reset are accepted and discarded until the FPU is also reset.
- Request queue: synchronous FIFO of DEPTH entries. A request is pushed when req_valid&&req_ready. req_ready=!full. A simultaneous push and pop when full is not allowed, because req_ready is already 0.
- Issue: fpu_in_valid=queue non-empty && credits>0 && state!=DRAIN. fpu_a/b/c/op/tag come from the queue head plus issue_tag. All of these are stable while fpu_in_valid is high and fpu_in_ready is low; valid is never withdrawn.
- On fpu_in_valid&&fpu_in_ready: pop the head, issue_tag++ (wraps), credits--.
- Minimum latency: a request accepted at edge N can be issued in the cycle after N.
- Result capture: fpu_out_ready=1 except in DRAIN, where it is also 1. Credits guarantee response-FIFO space.
- On fpu_out_valid: compare fpu_tag_o with exp_tag, then exp_tag++. A mismatch sets tag_err, which is cleared only by rst.
- In RUN, the result is pushed into the response FIFO (MAX_OUT entries). rsp_valid is asserted the cycle after capture.
- Response pop: on rsp_valid&&rsp_ready, credits++.
- Credits on the same cycle: an issue and a pop in the same cycle leave credits unchanged. credits never exceeds MAX_OUT and never goes below 0.
- In DRAIN, captured results are discarded and immediately credits++.
- FSM:
  - IDLE -> RUN when the queue is non-empty.
  - RUN -> IDLE when the queue is empty and credits==MAX_OUT (nothing in flight, nothing buffered).
  - Any state -> DRAIN on flush. Flush clears the request queue and the response FIFO. Credits are restored by the number of buffered responses dropped.
  - DRAIN -> IDLE when credits==MAX_OUT. exp_tag keeps tracking during DRAIN.
- Flush interactions:
  - A request pushed in the same cycle as flush is dropped.
  - An issue handshake in the flush cycle still completes and is counted in flight.
- Tag wrap: 2**TAGW >= MAX_OUT ensures the tags of in-flight ops are unique.

Test Plan:
1. Reset, then push one request (A=0x3F800000, B=0x40000000, op=ADD). FPU model with latency 2 returns 0x40400000 with tag 0 -> fpu_in_valid the cycle after accept; rsp_data=0x40400000, rsp_tag=0; state RUN->IDLE; tag_err=0.
2. fpu_in_ready held low for 5 cycles while 4 requests are queued -> fpu_a/b/c/op/tag stable throughout; req_ready=0 after the 4th push; the 5th request is stalled until the first issue.
3. rsp_ready=0 with MAX_OUT=4 and 6 requests -> exactly 4 issued, fpu_in_valid drops; raising rsp_ready resumes issue; tags 0..5 delivered in order.
4. 10 back-to-back ops with TAGW=3 -> tags wrap 7->0; rsp_tag sequence 0..7,0,1; tag_err stays 0.
5. FPU returns tag 2 while tag 1 is expected -> tag_err=1 the next cycle and stays 1 until rst.
6. Flush with 2 ops in flight and 3 queued -> state=DRAIN; the 2 results are discarded and no rsp_valid is produced; return to IDLE with credits=4; a new request then gets tag 2.

Source files
------------

// File: rtl/fpu_req_driver.sv
// Generic synchronous FIFO used for request and response buffering.
// Latency: a write is visible at the read port the cycle after the push.
// Backpressure: writes while full and reads while empty are ignored; clr empties it.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr  = wr_vld && (cnt != CW'(DEPTH));
  assign do_rd  = rd_rdy && (cnt != '0);
  assign rd_dat = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      if (do_wr && !do_rd)      cnt <= cnt + CW'(1);
      else if (do_rd && !do_wr) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Initiator-side driver: queues operand triples, issues them tagged to an fpnew-style unit, buffers results.
// Latency: issue the cycle after request accept; rsp_valid the cycle after result capture.
// Backpressure: req_ready drops when the queue is full; issue stalls when credits (in flight + buffered) run out.
module fpu_req_driver #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int TAGW    = 3,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [OPW-1:0]   req_op,
  output logic             fpu_in_valid,
  input  logic             fpu_in_ready,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [WIDTH-1:0] fpu_c,
  output logic [OPW-1:0]   fpu_op,
  output logic [TAGW-1:0]  fpu_tag,
  input  logic             fpu_out_valid,
  output logic             fpu_out_ready,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic [4:0]       fpu_status,
  input  logic [TAGW-1:0]  fpu_tag_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_status,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             busy,
  output logic             tag_err,
  output logic [1:0]       state
);
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int CCW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [OPW-1:0]   op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       status;
    logic [TAGW-1:0]  tag;
  } rsp_t;

  state_t          st;
  req_t            q_wr_dat;
  req_t            q_head;
  logic [QCW-1:0]  q_cnt;
  logic            q_vld;
  rsp_t            r_wr_dat;
  rsp_t            r_head;
  logic [CCW-1:0]  r_cnt;
  logic [CCW-1:0]  credits;
  logic [TAGW-1:0] issue_tag;
  logic [TAGW-1:0] exp_tag;
  logic            issue;
  logic            cap;
  logic            cap_trk;
  logic            cap_keep;
  logic            cap_drop;
  logic            rsp_pop;
  int              cred_nxt;

  assign q_wr_dat = '{a: req_a, b: req_b, c: req_c, op: req_op};
  assign q_vld    = (q_cnt != '0);
  assign req_ready = (q_cnt != QCW'(DEPTH));

  // Requests arriving alongside a flush are dropped with the rest of the queue.
  fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_req_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_vld (req_valid && !flush),
    .wr_dat (q_wr_dat),
    .rd_rdy (issue),
    .rd_dat (q_head),
    .cnt    (q_cnt)
  );

  assign fpu_in_valid = q_vld && (credits != '0) && (st != DRAIN);
  assign issue        = fpu_in_valid && fpu_in_ready;
  assign fpu_a        = q_head.a;
  assign fpu_b        = q_head.b;
  assign fpu_c        = q_head.c;
  assign fpu_op       = q_head.op;
  assign fpu_tag      = issue_tag;

  // Results are always accepted; credits reserve the response-FIFO slot ahead of time.
  assign fpu_out_ready = 1'b1;
  assign cap           = fpu_out_valid && fpu_out_ready;
  assign cap_trk       = cap && (st != IDLE);
  assign cap_keep      = cap && (st == RUN) && !flush;
  assign cap_drop      = cap && ((st == DRAIN) || ((st == RUN) && flush));

  assign r_wr_dat = '{data: fpu_result, status: fpu_status, tag: fpu_tag_o};

  fifo #(.W($bits(rsp_t)), .DEPTH(MAX_OUT)) u_rsp_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_vld (cap_keep),
    .wr_dat (r_wr_dat),
    .rd_rdy (rsp_ready),
    .rd_dat (r_head),
    .cnt    (r_cnt)
  );

  assign rsp_valid  = (r_cnt != '0);
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rsp_data   = r_head.data;
  assign rsp_status = r_head.status;
  assign rsp_tag    = r_head.tag;

  // On flush every buffered response returns its credit, including one popped that same cycle.
  always_comb begin
    cred_nxt = int'(credits) - int'(issue) + int'(cap_drop);
    if (flush) cred_nxt = cred_nxt + int'(r_cnt);
    else       cred_nxt = cred_nxt + int'(rsp_pop);
    if (cred_nxt > MAX_OUT) cred_nxt = MAX_OUT;
    if (cred_nxt < 0)       cred_nxt = 0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits   <= CCW'(MAX_OUT);
      issue_tag <= '0;
      exp_tag   <= '0;
      tag_err   <= 1'b0;
    end else begin
      credits <= CCW'(cred_nxt);
      if (issue) issue_tag <= issue_tag + TAGW'(1);
      if (cap_trk) begin
        exp_tag <= exp_tag + TAGW'(1);
        if (fpu_tag_o != exp_tag) tag_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      busy <= 1'b0;
    end else if (flush) begin
      st   <= DRAIN;
      busy <= 1'b1;
    end else begin
      case (st)
        IDLE: if (q_vld) begin
          st   <= RUN;
          busy <= 1'b1;
        end
        RUN: if (!q_vld && (credits == CCW'(MAX_OUT))) begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        DRAIN: if (credits == CCW'(MAX_OUT)) begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;
endmodule
